// File: rtl/gpio_regs_pkg.sv
// Shared register map, CPU port-select code and sizing helper for the GPIO bank block.
package gpio_regs_pkg;

   localparam logic [15:0] IO_BASE    = 16'h1000;
   localparam logic [15:0] DDR_BASE   = 16'h1100;
   localparam logic [15:0] MUX_BASE   = 16'h1120;
   localparam logic [15:0] OD_BASE    = 16'h1300;
   localparam logic [15:0] IRQEN_BASE = 16'h1400;
   localparam logic [15:0] IRQST_BASE = 16'h1500;

   localparam logic [7:0] PORTSEL_CPU = 8'hFF;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_RD,
      ACC_WR
   } access_t;

   function automatic int num_banks(input int np, input int bw);
      return (np + bw - 1) / bw;
   endfunction

endpackage

// File: rtl/gpio_pin_mux.sv
// Per-pin output source select (CPU IO bit or HM3 function) with open-drain/DDR pad drive registers.
module gpio_pin_mux
   import gpio_regs_pkg::*;
#(
   parameter int NP           = 144,
   parameter int PortNumWidth = 8
)(
   input  logic                    reg_clk,
   input  logic                    reset_in,
   input  logic [PortNumWidth-1:0] sel,
   input  logic                    io_bit,
   input  logic                    ddr_bit,
   input  logic                    od_bit,
   input  logic [NP-1:0]           hm3_data,
   output logic                    pad_out,
   output logic                    pad_oe
);

   localparam int IdxW = (NP > 1) ? $clog2(NP) : 1;

   logic            src;
   logic [IdxW-1:0] hm3_idx;

   // Selectors that name no existing HM3 output fall back to the CPU IO bit
   always_comb begin
      hm3_idx = IdxW'(sel);
      if ((sel == PortNumWidth'(PORTSEL_CPU)) || (int'(sel) >= NP)) begin
         src = io_bit;
      end else begin
         src = hm3_data[hm3_idx];
      end
   end

   // Open-drain pins only ever pull low, so the enable carries the inverted data
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         pad_out <= 1'b0;
         pad_oe  <= 1'b0;
      end else if (od_bit) begin
         pad_out <= 1'b0;
         pad_oe  <= ~src;
      end else begin
         pad_out <= src;
         pad_oe  <= ddr_bit;
      end
   end

endmodule

// File: rtl/gpio_bank_regs.sv
// GPIO register bank and decoder on the HM2/HM3 CPU bus: IO/DDR/MUX/OD banks, input sync, pad drive.
// Edge-capture interrupt banks are built only when GPIO_EDGE_IRQ_EN is defined.
module gpio_bank_regs
   import gpio_regs_pkg::*;
#(
   parameter int AddrWidth    = 16,
   parameter int BusWidth     = 32,
   parameter int NumGPIO      = 4,
   parameter int GPIOWidth    = 36,
   parameter int BankWidth    = 24,
   parameter int PortNumWidth = 8
)(
   input  logic                           reg_clk,
   input  logic                           reset_in,
   input  logic                           read_reg,
   input  logic                           write_reg,
   input  logic [AddrWidth-3:0]           busaddress,
   input  logic [BusWidth-1:0]            busdata_in,
   input  logic [BusWidth-1:0]            busdata_fromhm2,
   output logic [BusWidth-1:0]            busdata_to_cpu,
   input  logic [NumGPIO*GPIOWidth-1:0]   iodatafromhm3,
   output logic [NumGPIO*GPIOWidth-1:0]   iodatatohm3,
   input  logic [NumGPIO*GPIOWidth-1:0]   gpio_in,
   output logic [NumGPIO*GPIOWidth-1:0]   gpio_out,
   output logic [NumGPIO*GPIOWidth-1:0]   gpio_oe,
   output logic                           irq
);

   localparam int NP       = NumGPIO * GPIOWidth;
   localparam int NB       = num_banks(NP, BankWidth);
   localparam int NW       = num_banks(NP, 4);
   localparam int NBW      = NB * BankWidth;
   localparam int MuxWordW = 4 * PortNumWidth;

   logic                 rd_q, rd_qq, wr_q, wr_qq;
   logic [AddrWidth-3:0] addr_q;
   logic [BusWidth-1:0]  data_q;
   logic                 rd_pulse, wr_pulse;
   access_t              access;

   // Strobe history resets high so a strobe still held across reset is not seen as a new access
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         rd_q   <= 1'b1;
         rd_qq  <= 1'b1;
         wr_q   <= 1'b1;
         wr_qq  <= 1'b1;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         rd_q   <= read_reg;
         rd_qq  <= rd_q;
         wr_q   <= write_reg;
         wr_qq  <= wr_q;
         addr_q <= busaddress;
         data_q <= busdata_in;
      end
   end

   assign rd_pulse = rd_q & ~rd_qq;
   assign wr_pulse = wr_q & ~wr_qq;
   assign access   = wr_pulse ? ACC_WR : (rd_pulse ? ACC_RD : ACC_IDLE);

   function automatic logic in_region(input int a, input logic [15:0] base, input int words);
      return (a >= int'(base)) && (a < int'(base) + 4 * words);
   endfunction

   int   addr_int;
   logic io_hit, ddr_hit, mux_hit, od_hit, irqen_hit, irqst_hit;
   int   io_idx, ddr_idx, mux_idx, od_idx;

   always_comb begin
      addr_int  = int'({addr_q, 2'b00});
      io_hit    = in_region(addr_int, IO_BASE, NB);
      ddr_hit   = in_region(addr_int, DDR_BASE, NB);
      mux_hit   = in_region(addr_int, MUX_BASE, NW);
      od_hit    = in_region(addr_int, OD_BASE, NB);
      irqen_hit = in_region(addr_int, IRQEN_BASE, NB);
      irqst_hit = in_region(addr_int, IRQST_BASE, NB);
      io_idx    = (addr_int - int'(IO_BASE)) / 4;
      ddr_idx   = (addr_int - int'(DDR_BASE)) / 4;
      mux_idx   = (addr_int - int'(MUX_BASE)) / 4;
      od_idx    = (addr_int - int'(OD_BASE)) / 4;
   end

   logic [NP-1:0]           sync1, sync2;
   logic [NP-1:0]           io_reg, ddr_reg, od_reg;
   logic [PortNumWidth-1:0] mux_sel [NP];

   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
      end
   end

   assign iodatatohm3 = sync2;

   // Each pin picks up its bit from whichever bank word the committed write addresses
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         io_reg  <= '0;
         ddr_reg <= '0;
         od_reg  <= '0;
         for (int p = 0; p < NP; p++) begin
            mux_sel[p] <= PortNumWidth'(p % 256);
         end
      end else if (access == ACC_WR) begin
         for (int p = 0; p < NP; p++) begin
            if (io_hit && (io_idx == p / BankWidth)) begin
               io_reg[p] <= data_q[p % BankWidth];
            end
            if (ddr_hit && (ddr_idx == p / BankWidth)) begin
               ddr_reg[p] <= data_q[p % BankWidth];
            end
            if (od_hit && (od_idx == p / BankWidth)) begin
               od_reg[p] <= data_q[p % BankWidth];
            end
            if (mux_hit && (mux_idx == p / 4)) begin
               mux_sel[p] <= data_q[PortNumWidth*(p % 4) +: PortNumWidth];
            end
         end
      end
   end

`ifdef GPIO_EDGE_IRQ_EN
   logic [NP-1:0] sync3, irq_en_reg, irq_stat_reg, irq_set, irq_clr;
   logic [NBW-1:0] irqen_pad, irqst_pad;
   logic          irq_q;
   int            irqen_idx, irqst_idx;

   always_comb begin
      irqen_idx = (addr_int - int'(IRQEN_BASE)) / 4;
      irqst_idx = (addr_int - int'(IRQST_BASE)) / 4;
      irq_set   = sync2 & ~sync3 & irq_en_reg;
      irq_clr   = '0;
      for (int p = 0; p < NP; p++) begin
         irq_clr[p] = (access == ACC_WR) && irqst_hit && (irqst_idx == p / BankWidth)
                      && data_q[p % BankWidth];
      end
      irqen_pad = NBW'(irq_en_reg);
      irqst_pad = NBW'(irq_stat_reg);
   end

   // A fresh edge in the same cycle as its write-1-to-clear keeps the status bit set
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         sync3        <= '0;
         irq_en_reg   <= '0;
         irq_stat_reg <= '0;
         irq_q        <= 1'b0;
      end else begin
         sync3        <= sync2;
         irq_stat_reg <= (irq_stat_reg & ~irq_clr) | irq_set;
         irq_q        <= |irq_stat_reg;
         if (access == ACC_WR) begin
            for (int p = 0; p < NP; p++) begin
               if (irqen_hit && (irqen_idx == p / BankWidth)) begin
                  irq_en_reg[p] <= data_q[p % BankWidth];
               end
            end
         end
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   logic [NBW-1:0]         io_pad, ddr_pad, od_pad;
   logic [NW*MuxWordW-1:0] mux_flat;
   logic [BusWidth-1:0]    rd_next;

   // IO reads report the synchronised pins, not the CPU output latch
   always_comb begin
      io_pad   = NBW'(sync2);
      ddr_pad  = NBW'(ddr_reg);
      od_pad   = NBW'(od_reg);
      mux_flat = '0;
      for (int p = 0; p < NP; p++) begin
         mux_flat[p*PortNumWidth +: PortNumWidth] = mux_sel[p];
      end
      rd_next = busdata_fromhm2;
      for (int b = 0; b < NB; b++) begin
         if (io_hit && (io_idx == b)) begin
            rd_next = BusWidth'(io_pad[b*BankWidth +: BankWidth]);
         end
         if (ddr_hit && (ddr_idx == b)) begin
            rd_next = BusWidth'(ddr_pad[b*BankWidth +: BankWidth]);
         end
         if (od_hit && (od_idx == b)) begin
            rd_next = BusWidth'(od_pad[b*BankWidth +: BankWidth]);
         end
      end
`ifdef GPIO_EDGE_IRQ_EN
      for (int b = 0; b < NB; b++) begin
         if (irqen_hit && (irqen_idx == b)) begin
            rd_next = BusWidth'(irqen_pad[b*BankWidth +: BankWidth]);
         end
         if (irqst_hit && (irqst_idx == b)) begin
            rd_next = BusWidth'(irqst_pad[b*BankWidth +: BankWidth]);
         end
      end
`else
      if (irqen_hit || irqst_hit) begin
         rd_next = '0;
      end
`endif
      for (int w = 0; w < NW; w++) begin
         if (mux_hit && (mux_idx == w)) begin
            rd_next = BusWidth'(mux_flat[w*MuxWordW +: MuxWordW]);
         end
      end
   end

   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         busdata_to_cpu <= '0;
      end else if (rd_pulse) begin
         busdata_to_cpu <= rd_next;
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_pin
      gpio_pin_mux #(
         .NP           (NP),
         .PortNumWidth (PortNumWidth)
      ) u_pin (
         .reg_clk  (reg_clk),
         .reset_in (reset_in),
         .sel      (mux_sel[p]),
         .io_bit   (io_reg[p]),
         .ddr_bit  (ddr_reg[p]),
         .od_bit   (od_reg[p]),
         .hm3_data (iodatafromhm3),
         .pad_out  (gpio_out[p]),
         .pad_oe   (gpio_oe[p])
      );
   end

endmodule

// File: tb/tb_gpio_bank_regs.sv
// Self-checking bench for gpio_bank_regs: bus transaction table with a scoreboard plus corner sequences.
module tb_gpio_bank_regs;

   localparam int NP = 144;

   logic          reg_clk = 1'b0;
   logic          reset_in;
   logic          read_reg;
   logic          write_reg;
   logic [13:0]   busaddress;
   logic [31:0]   busdata_in;
   logic [31:0]   busdata_fromhm2;
   logic [31:0]   busdata_to_cpu;
   logic [NP-1:0] iodatafromhm3;
   logic [NP-1:0] iodatatohm3;
   logic [NP-1:0] gpio_in;
   logic [NP-1:0] gpio_out;
   logic [NP-1:0] gpio_oe;
   logic          irq;

   gpio_bank_regs dut (
      .reg_clk         (reg_clk),
      .reset_in        (reset_in),
      .read_reg        (read_reg),
      .write_reg       (write_reg),
      .busaddress      (busaddress),
      .busdata_in      (busdata_in),
      .busdata_fromhm2 (busdata_fromhm2),
      .busdata_to_cpu  (busdata_to_cpu),
      .iodatafromhm3   (iodatafromhm3),
      .iodatatohm3     (iodatatohm3),
      .gpio_in         (gpio_in),
      .gpio_out        (gpio_out),
      .gpio_oe         (gpio_oe),
      .irq             (irq)
   );

   always #5 reg_clk = ~reg_clk;

   typedef struct {
      string       name;
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oe;
   } vec_t;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   vectors_applied = 0;
   int   miscompares = 0;

   function automatic vec_t mk(input string name, input bit wr, input logic [15:0] addr,
                               input logic [31:0] wdata, input int hold, input logic [31:0] exp_rd,
                               input logic [7:0] exp_out, input logic [7:0] exp_oe);
      vec_t v;
      v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.hold = hold;
      v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_oe = exp_oe;
      return v;
   endfunction

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors_applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Strobes are driven for 'hold' cycles, then the bus idles long enough for the pads to settle
   task automatic do_access(input bit wr, input bit rd, input logic [15:0] addr,
                            input logic [31:0] data, input int hold);
      @(negedge reg_clk);
      busaddress = addr[15:2];
      busdata_in = data;
      write_reg  = wr;
      read_reg   = rd;
      repeat (hold) @(negedge reg_clk);
      write_reg = 1'b0;
      read_reg  = 1'b0;
      repeat (3) @(negedge reg_clk);
   endtask

   task automatic push_exp(input string name, input int kind, input logic [31:0] exp);
      sb_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input vec_t v);
      do_access(v.wr, !v.wr, v.addr, v.wdata, v.hold);
      if (!v.wr) push_exp({v.name, "_rd"}, 0, v.exp_rd);
      push_exp({v.name, "_out"}, 1, {24'h0, v.exp_out});
      push_exp({v.name, "_oe"}, 2, {24'h0, v.exp_oe});
   endtask

   task automatic checkOutput();
      sb_t         e;
      logic [31:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       act = busdata_to_cpu;
            1:       act = {24'h0, gpio_out[7:0]};
            default: act = {24'h0, gpio_oe[7:0]};
         endcase
         compare(e.name, act, e.exp);
      end
   endtask

   task automatic read_check(input string name, input logic [15:0] addr, input logic [31:0] exp);
      do_access(1'b0, 1'b1, addr, 32'h0, 1);
      compare(name, busdata_to_cpu, exp);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] irqen_rb;
      reset_in        = 1'b1;
      read_reg        = 1'b0;
      write_reg       = 1'b0;
      busaddress      = '0;
      busdata_in      = '0;
      busdata_fromhm2 = 32'hDEADBEEF;
      iodatafromhm3   = NP'(8'h3C);
      gpio_in         = '0;

      repeat (2) @(negedge reg_clk);
      reset_in = 1'b0;
      #1;
      compare("rst_busdata", busdata_to_cpu, 32'h0);
      compare("rst_gpio_out", 32'(|gpio_out), 32'h0);
      compare("rst_gpio_oe", 32'(|gpio_oe), 32'h0);
      compare("rst_irq", 32'(irq), 32'h0);
      compare("rst_tohm3", 32'(|iodatatohm3), 32'h0);

      // Reset lands between the registered strobe and its commit; the held strobe must not fire afterwards
      @(negedge reg_clk);
      busaddress = 14'(16'h1100 >> 2);
      busdata_in = 32'h00FFFFFF;
      write_reg  = 1'b1;
      @(negedge reg_clk);
      reset_in = 1'b1;
      @(negedge reg_clk);
      reset_in = 1'b0;
      repeat (3) @(negedge reg_clk);
      write_reg = 1'b0;
      repeat (3) @(negedge reg_clk);
      compare("midrst_oe", 32'(|gpio_oe), 32'h0);
      read_check("midrst_ddr", 16'h1100, 32'h0);
      read_check("midrst_mux0", 16'h1120, 32'h03020100);

`ifdef GPIO_EDGE_IRQ_EN
      irqen_rb = 32'h1;
`else
      irqen_rb = 32'h0;
`endif
      vecs.push_back(mk("ddr_ff",      1, 16'h1100, 32'h000000FF, 3, 0, 8'h3C, 8'hFF));
      vecs.push_back(mk("mux0_cpu",    1, 16'h1120, 32'hFFFFFFFF, 1, 0, 8'h30, 8'hFF));
      vecs.push_back(mk("mux1_cpu",    1, 16'h1124, 32'hFFFFFFFF, 1, 0, 8'h00, 8'hFF));
      vecs.push_back(mk("io_a5_hold3", 1, 16'h1000, 32'h000000A5, 3, 0, 8'hA5, 8'hFF));
      vecs.push_back(mk("rd_io_pins",  0, 16'h1000, 0, 1, 32'h0,        8'hA5, 8'hFF));
      vecs.push_back(mk("rd_ddr0",     0, 16'h1100, 0, 1, 32'h000000FF, 8'hA5, 8'hFF));
      vecs.push_back(mk("rd_ddr1",     0, 16'h1104, 0, 1, 32'h0,        8'hA5, 8'hFF));
      vecs.push_back(mk("io_5a",       1, 16'h1000, 32'hFFFFFF5A, 1, 0, 8'h5A, 8'hFF));
      vecs.push_back(mk("rd_mux2",     0, 16'h1128, 0, 1, 32'h0B0A0908, 8'h5A, 8'hFF));
      vecs.push_back(mk("rd_mux_last", 0, 16'h11AC, 0, 1, 32'h8F8E8D8C, 8'h5A, 8'hFF));
      vecs.push_back(mk("rd_mux0",     0, 16'h1120, 0, 1, 32'hFFFFFFFF, 8'h5A, 8'hFF));
      vecs.push_back(mk("od3_src1",    1, 16'h1300, 32'h00000008, 1, 0, 8'h52, 8'hF7));
      vecs.push_back(mk("od3_src0",    1, 16'h1000, 32'h00000052, 1, 0, 8'h52, 8'hFF));
      vecs.push_back(mk("od3_ddr0",    1, 16'h1100, 32'h00000000, 1, 0, 8'h52, 8'h08));
      vecs.push_back(mk("rd_od0",      0, 16'h1300, 0, 1, 32'h00000008, 8'h52, 8'h08));
      vecs.push_back(mk("od_clear",    1, 16'h1300, 32'h00000000, 1, 0, 8'h52, 8'h00));
      vecs.push_back(mk("ddr_restore", 1, 16'h1100, 32'h000000FF, 1, 0, 8'h52, 8'hFF));
      vecs.push_back(mk("rd_unmapped", 0, 16'h0800, 0, 1, 32'hDEADBEEF, 8'h52, 8'hFF));
      vecs.push_back(mk("rd_ddr_past", 0, 16'h1118, 0, 1, 32'hDEADBEEF, 8'h52, 8'hFF));
      vecs.push_back(mk("rd_mux_past", 0, 16'h11B0, 0, 1, 32'hDEADBEEF, 8'h52, 8'hFF));
      vecs.push_back(mk("rd_io_past",  0, 16'h1018, 0, 1, 32'hDEADBEEF, 8'h52, 8'hFF));
      vecs.push_back(mk("irqen_wr",    1, 16'h1400, 32'h00000001, 1, 0, 8'h52, 8'hFF));
      vecs.push_back(mk("rd_irqen0",   0, 16'h1400, 0, 1, irqen_rb,     8'h52, 8'hFF));
      vecs.push_back(mk("rd_irqen1",   0, 16'h1404, 0, 1, 32'h0,        8'h52, 8'hFF));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      // Read and write in the same pulse: read sees the value before the write
      do_access(1'b1, 1'b1, 16'h1100, 32'h0000000F, 1);
      compare("rdwr_old", busdata_to_cpu, 32'h000000FF);
      compare("rdwr_oe", {24'h0, gpio_oe[7:0]}, 32'h0000000F);
      read_check("rdwr_new", 16'h1100, 32'h0000000F);
      do_access(1'b1, 1'b0, 16'h1100, 32'h000000FF, 1);

      // Pin 0 follows HM3 output 5, pin 1 HM3 output 0, pins 2..3 the CPU IO bits
      iodatafromhm3 = '0;
      do_access(1'b1, 1'b0, 16'h1000, 32'h0000000F, 1);
      do_access(1'b1, 1'b0, 16'h1120, 32'hFFFF0005, 1);
      compare("mux_sel5", {28'h0, gpio_out[3:0]}, 32'h0000000C);
      iodatafromhm3[5] = 1'b1;
      #1;
      compare("hm3_before_edge", 32'(gpio_out[0]), 32'h0);
      @(negedge reg_clk);
      compare("hm3_follow", {28'h0, gpio_out[3:0]}, 32'h0000000D);
      iodatafromhm3[5] = 1'b0;
      @(negedge reg_clk);
      compare("hm3_follow_low", {28'h0, gpio_out[3:0]}, 32'h0000000C);

      gpio_in[30] = 1'b1;
      @(negedge reg_clk);
      compare("sync_stage1", 32'(iodatatohm3[30]), 32'h0);
      @(negedge reg_clk);
      compare("sync_stage2", 32'(iodatatohm3[30]), 32'h1);
      read_check("rd_io_bank1", 16'h1004, 32'h00000040);

      gpio_in[0] = 1'b1;
      repeat (4) @(negedge reg_clk);
`ifdef GPIO_EDGE_IRQ_EN
      compare("irq_set", 32'(irq), 32'h1);
      read_check("irqst_set", 16'h1500, 32'h00000001);
      gpio_in[0] = 1'b0;
      repeat (4) @(negedge reg_clk);
      gpio_in[0] = 1'b1;
      do_access(1'b1, 1'b0, 16'h1500, 32'h00000001, 1);
      read_check("irqst_set_wins", 16'h1500, 32'h00000001);
      do_access(1'b1, 1'b0, 16'h1500, 32'h00000001, 1);
      read_check("irqst_w1c", 16'h1500, 32'h0);
      compare("irq_cleared", 32'(irq), 32'h0);
`else
      compare("irq_tied", 32'(irq), 32'h0);
      read_check("irqst_absent", 16'h1500, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
